replay_bar_ctrl: RTL and testbench

- Sequential controller upstream of the game-over/replay screen renderer.
- Debounces the replay push-button and measures how long it is held, counted in OLED frame ticks.
- Drives a 0..4 segment fill level for the four-segment loading bar drawn on that screen.
- When all four segments are full, emits a one-cycle replay pulse to the top-level game FSM.

---
 rtl/replay_bar_ctrl.sv | 171 +++++++++++++++++
 tb/tb_replay_bar_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/replay_bar_ctrl.sv
// Replay-screen loading bar: debounces the replay button, fills a four-segment bar
// while it is held (draining it when released) and strobes replay_pulse when full.
module replay_bar_ctrl #(
    parameter int DEB_LEN   = 16,
    parameter int STEP_LEN  = 20,
    parameter int DECAY_LEN = 10,
    parameter int DONE_HOLD = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       btn_raw,
    input  logic       frame_tick,
    output logic [2:0] level,
    output logic [3:0] seg_fill,
    output logic       replay_pulse,
    output logic       busy
);

    localparam int TMAX_A = (STEP_LEN > DECAY_LEN) ? STEP_LEN : DECAY_LEN;
    localparam int TMAX   = (TMAX_A > DONE_HOLD) ? TMAX_A : DONE_HOLD;
    localparam int TW     = $clog2(TMAX) + 1;
    localparam int DW     = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_LEN - 1);
    localparam logic [TW-1:0] STEP_LAST  = TW'(STEP_LEN - 1);
    localparam logic [TW-1:0] DECAY_LAST = TW'(DECAY_LEN - 1);
    localparam logic [TW-1:0] DONE_LAST  = TW'(DONE_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHARGE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    logic          sync1_q, sync2_q;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          btn_db_q, btn_db_d;

    state_t        state_q, state_d;
    logic [2:0]    level_q, level_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          pulse_q, pulse_d;
    logic [3:0]    seg_fill_q, seg_fill_d;
    logic          busy_q;

    // Debounce: the synchronised level must disagree for DEB_LEN cycles in a row.
    always_comb begin
        deb_cnt_d = '0;
        btn_db_d  = btn_db_q;
        if (sync2_q != btn_db_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                btn_db_d = ~btn_db_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        tcnt_d  = tcnt_q;
        pulse_d = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            level_d = 3'd0;
            tcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    level_d = 3'd0;
                    tcnt_d  = '0;
                    if (btn_db_q) state_d = CHARGE;
                end
                CHARGE: begin
                    if (!btn_db_q) begin
                        state_d = DRAIN;
                        tcnt_d  = '0;
                    end else if (frame_tick) begin
                        if (tcnt_q == STEP_LAST) begin
                            tcnt_d = '0;
                            if (level_q >= 3'd3) begin
                                level_d = 3'd4;
                                state_d = DONE;
                                pulse_d = 1'b1;
                            end else begin
                                level_d = level_q + 3'd1;
                            end
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (btn_db_q) begin
                        state_d = CHARGE;
                        tcnt_d  = '0;
                    end else if (level_q == 3'd0) begin
                        // Released before the first segment filled: nothing to drain.
                        state_d = IDLE;
                        tcnt_d  = '0;
                    end else if (frame_tick) begin
                        if (tcnt_q == DECAY_LAST) begin
                            tcnt_d  = '0;
                            level_d = level_q - 3'd1;
                            if (level_q == 3'd1) state_d = IDLE;
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    level_d = 3'd4;
                    if ((tcnt_q == DONE_LAST) && !btn_db_q) begin
                        state_d = IDLE;
                        level_d = 3'd0;
                        tcnt_d  = '0;
                    end else if (frame_tick && (tcnt_q != DONE_LAST)) begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    level_d = 3'd0;
                    tcnt_d  = '0;
                end
            endcase
        end
    end

    // Thermometer is derived from the next level so it lands on the same edge.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_therm
            assign seg_fill_d[gi] = (level_d > 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_cnt_q  <= '0;
            btn_db_q   <= 1'b0;
            state_q    <= IDLE;
            level_q    <= 3'd0;
            tcnt_q     <= '0;
            pulse_q    <= 1'b0;
            seg_fill_q <= 4'd0;
            busy_q     <= 1'b0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_cnt_q  <= deb_cnt_d;
            btn_db_q   <= btn_db_d;
            state_q    <= state_d;
            level_q    <= level_d;
            tcnt_q     <= tcnt_d;
            pulse_q    <= pulse_d;
            seg_fill_q <= seg_fill_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    assign level        = level_q;
    assign seg_fill     = seg_fill_q;
    assign replay_pulse = pulse_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_replay_bar_ctrl.sv
// Scoreboard bench for replay_bar_ctrl: stimulus queues the expected output changes
// (with the clock edge they must appear on); a monitor pops them as outputs change.
module tb_replay_bar_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       btn_raw;
    logic       frame_tick;
    logic [2:0] level;
    logic [3:0] seg_fill;
    logic       replay_pulse;
    logic       busy;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        int         stamp;
        logic       b;
        logic [2:0] lvl;
        logic       p;
    } ev_t;

    ev_t exp_q[$];

    replay_bar_ctrl #(
        .DEB_LEN  (4),
        .STEP_LEN (3),
        .DECAY_LEN(2),
        .DONE_HOLD(5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .btn_raw     (btn_raw),
        .frame_tick  (frame_tick),
        .level       (level),
        .seg_fill    (seg_fill),
        .replay_pulse(replay_pulse),
        .busy        (busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame ticks are sampled on every edge whose number is a multiple of 10.
    initial begin
        frame_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            frame_tick = (((cyc + 1) % 10) == 0);
        end
    end

    function automatic logic [3:0] therm(input logic [2:0] l);
        logic [3:0] t;
        for (int i = 0; i < 4; i++) t[i] = (l > 3'(i));
        return t;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
    endtask

    task automatic push(input int stamp, input logic b, input int lvl, input logic p);
        ev_t e;
        e.stamp = stamp;
        e.b     = b;
        e.lvl   = 3'(lvl);
        e.p     = p;
        exp_q.push_back(e);
    endtask

    task automatic goto(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: any change of the output bundle is one transaction.
    initial begin
        logic [8:0] prev;
        logic [8:0] snap;
        ev_t        e;
        prev = 9'd0;
        forever begin
            @(negedge clk);
            snap = {busy, level, seg_fill, replay_pulse};
            if (snap !== prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_change", int'(snap), int'(prev));
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle", cyc, e.stamp);
                    check("event_outputs", int'(snap), int'({e.b, e.lvl, therm(e.lvl), e.p}));
                    $display("cycle %0d: busy=%0b level=%0d seg_fill=%b pulse=%0b",
                             cyc, busy, level, seg_fill, replay_pulse);
                end
                prev = snap;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        btn_raw = 1'b1;
        enable  = 1'b1;

        // Reset with button held, then full charge and a 20-tick hold in DONE.
        push(10, 1, 0, 0);
        push(40, 1, 1, 0);
        push(70, 1, 2, 0);
        push(100, 1, 3, 0);
        push(130, 1, 4, 1);
        push(131, 1, 4, 0);
        push(337, 0, 0, 0);
        for (int e = 1; e <= 3; e++) begin
            goto(e);
            check("reset_outputs", int'({busy, level, seg_fill, replay_pulse}), 0);
        end
        rst_n = 1'b1;
        goto(330);
        btn_raw = 1'b0;

        // Bounce: toggling every 2 cycles never lasts long enough to debounce.
        for (int i = 0; i < 20; i++) begin
            goto(400 + 2 * i);
            btn_raw = ~btn_raw;
        end
        goto(445);
        check("bounce_idle", int'({busy, level}), 0);

        // Partial charge to 2, release and drain back to IDLE.
        push(507, 1, 0, 0);
        push(530, 1, 1, 0);
        push(560, 1, 2, 0);
        push(590, 1, 1, 0);
        push(610, 0, 0, 0);
        goto(500);
        btn_raw = 1'b1;
        goto(572);
        btn_raw = 1'b0;

        // Re-press while draining at level 1, then charge to full.
        push(707, 1, 0, 0);
        push(730, 1, 1, 0);
        push(760, 1, 2, 0);
        push(780, 1, 1, 0);
        push(810, 1, 2, 0);
        push(840, 1, 3, 0);
        push(870, 1, 4, 1);
        push(871, 1, 4, 0);
        push(911, 0, 0, 0);
        goto(700);
        btn_raw = 1'b1;
        goto(762);
        btn_raw = 1'b0;
        goto(782);
        btn_raw = 1'b1;
        goto(872);
        btn_raw = 1'b0;

        // Drop enable at level 3: immediate abort, no pulse.
        push(1007, 1, 0, 0);
        push(1030, 1, 1, 0);
        push(1060, 1, 2, 0);
        push(1090, 1, 3, 0);
        push(1093, 0, 0, 0);
        goto(1000);
        btn_raw = 1'b1;
        goto(1092);
        enable = 1'b0;
        goto(1095);
        btn_raw = 1'b0;
        goto(1110);
        enable = 1'b1;

        // Reset asserted at level 3 aborts on the next edge.
        push(1207, 1, 0, 0);
        push(1230, 1, 1, 0);
        push(1260, 1, 2, 0);
        push(1290, 1, 3, 0);
        push(1293, 0, 0, 0);
        goto(1200);
        btn_raw = 1'b1;
        goto(1292);
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        goto(1295);
        rst_n = 1'b1;

        goto(1400);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
